// File: rtl/srio_type9_pack.sv
// SRIO type 9 packer: segments 64-bit AXIS PDUs into header + payload packets.
// Ports: AXIS_ACLK/AXIS_ARESET, cfg_*, S_AXIS_* PDU in, M_AXIS_* packets out, pdu_count, len_sat_err.
module srio_type9_pack #(
  parameter int MTU_BEATS = 32,
  parameter int BUF_AW    = 8
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic        cfg_enable,
  input  logic [15:0] cfg_stream_id,
  input  logic [7:0]  cfg_cos,
  input  logic [1:0]  cfg_prio,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [63:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic [31:0] pdu_count,
  output logic        len_sat_err
);

  typedef enum logic [1:0] {IDLE, FILL, HDR, DATA} state_t;

  localparam logic [BUF_AW:0] ONE      = 1;
  localparam logic [BUF_AW:0] MTU_LAST = (BUF_AW+1)'(MTU_BEATS - 1);

  state_t state, state_nx;

  logic [63:0]     mem [2**BUF_AW];
  logic [BUF_AW:0] wr_cnt, rd_ptr;
  logic [15:0]     byte_len, sh_sid;
  logic [7:0]      sh_cos, seg_idx;
  logic [1:0]      sh_prio;
  logic            first_seg, last_seg;
  logic            in_hs, out_hs, seg_full, data_last;
  logic [63:0]     hdr;

  assign in_hs     = S_AXIS_TVALID & S_AXIS_TREADY;
  assign out_hs    = M_AXIS_TVALID & M_AXIS_TREADY;
  assign seg_full  = (wr_cnt == MTU_LAST);
  assign data_last = (rd_ptr == wr_cnt - ONE);

  assign hdr = {4'h9, sh_prio, 1'b0, first_seg, last_seg, 7'd0,
                sh_cos, sh_sid, seg_idx,
                last_seg ? byte_len : 16'h0};

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cfg_enable) state_nx = FILL;
      FILL: if (in_hs && (S_AXIS_TLAST || seg_full)) state_nx = HDR;
      HDR:  if (out_hs) state_nx = DATA;
      DATA: if (out_hs && data_last)
              state_nx = last_seg ? IDLE : FILL;
      default: state_nx = IDLE;
    endcase
  end

  // Payload is read combinationally so the next beat is
  // ready on the cycle after each handshake: no bubbles.
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TDATA  = 64'h0;
    unique case (state)
      FILL: S_AXIS_TREADY = 1'b1;
      HDR: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = hdr;
      end
      DATA: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = data_last;
        M_AXIS_TDATA  = mem[rd_ptr[BUF_AW-1:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (in_hs) mem[wr_cnt[BUF_AW-1:0]] <= S_AXIS_TDATA;
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      byte_len    <= '0;
      sh_sid      <= '0;
      sh_cos      <= '0;
      sh_prio     <= '0;
      seg_idx     <= '0;
      first_seg   <= 1'b1;
      last_seg    <= 1'b0;
      pdu_count   <= '0;
      len_sat_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (cfg_enable) begin
          sh_sid  <= cfg_stream_id;
          sh_cos  <= cfg_cos;
          sh_prio <= cfg_prio;
        end
        FILL: if (in_hs) begin
          wr_cnt <= wr_cnt + ONE;
          if (byte_len > 16'hFFF7) begin
            byte_len    <= 16'hFFFF;
            len_sat_err <= 1'b1;
          end else begin
            byte_len <= byte_len + 16'd8;
          end
          if (S_AXIS_TLAST || seg_full) last_seg <= S_AXIS_TLAST;
        end
        HDR: if (out_hs) rd_ptr <= '0;
        DATA: if (out_hs) begin
          rd_ptr <= rd_ptr + ONE;
          if (data_last) begin
            wr_cnt    <= '0;
            first_seg <= 1'b0;
            seg_idx   <= seg_idx + 8'd1;
            if (last_seg) begin
              pdu_count <= pdu_count + 32'd1;
              first_seg <= 1'b1;
              seg_idx   <= '0;
              byte_len  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srio_type9_pack.sv
// Bench for srio_type9_pack: random PDUs vs a segment-level model.
// Drives inputs on negedge, samples 1ns later.
module tb_srio_type9_pack;

  localparam int MTU = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [15:0] cfg_stream_id;
  logic [7:0]  cfg_cos;
  logic [1:0]  cfg_prio;
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [63:0] m_tdata;
  logic [31:0] pdu_count;
  logic        len_sat_err;

  int checks = 0;
  int errors = 0;
  int exp_pdus = 0;

  logic [63:0] pdu_q [$];
  logic [64:0] exp_q [$];
  logic [64:0] got_q [$];

  always #5 clk = ~clk;

  srio_type9_pack #(.MTU_BEATS(MTU), .BUF_AW(8)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .cfg_enable    (cfg_enable),
    .cfg_stream_id (cfg_stream_id),
    .cfg_cos       (cfg_cos),
    .cfg_prio      (cfg_prio),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast),
    .pdu_count     (pdu_count),
    .len_sat_err   (len_sat_err)
  );

  task automatic chk(string tag, logic [64:0] obs, logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packet stream derived from the segmentation rules.
  function automatic void build_exp(int n, logic [15:0] s,
                                    logic [7:0] c, logic [1:0] p);
    int segs, len, b;
    logic [63:0] h;
    bit first, lst;
    exp_q.delete();
    segs = (n + MTU - 1) / MTU;
    len  = (n * 8 > 65535) ? 65535 : n * 8;
    for (int sg = 0; sg < segs; sg++) begin
      b     = (n - sg * MTU < MTU) ? n - sg * MTU : MTU;
      first = (sg == 0);
      lst   = (sg == segs - 1);
      h = (64'h9 << 60) + (64'(p) << 58) + (64'(first) << 56)
        + (64'(lst) << 55) + (64'(c) << 40) + (64'(s) << 24)
        + (64'(sg % 256) << 16) + (lst ? 64'(len) : 64'd0);
      exp_q.push_back({1'b0, h});
      for (int k = 0; k < b; k++)
        exp_q.push_back({k == b - 1, pdu_q[sg * MTU + k]});
    end
  endfunction

  task automatic send(int n, bit with_last, int drop_at);
    bit acc;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) begin
        cfg_enable    = 1'b0;
        cfg_stream_id = 16'h5555;
      end
      s_tvalid = 1'b1;
      s_tdata  = pdu_q[i];
      s_tlast  = with_last && (i == n - 1);
      acc = 1'b0;
      for (int g = 0; g < 4000 && !acc; g++) begin
        #1;
        acc = s_tready;
        @(negedge clk);
      end
      if (!acc) begin
        chk("in_timeout", 65'(acc), 65'd1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic collect(int n, int pct);
    bit stalled = 1'b0;
    bit mid_pkt = 1'b0;
    logic [63:0] held = '0;
    got_q.delete();
    for (int g = 0; g < 40000 && got_q.size() < n; g++) begin
      m_tready = ($urandom_range(99) < pct);
      #1;
      if (stalled) begin
        chk("stall_valid", 65'(m_tvalid), 65'd1);
        chk("stall_data", {1'b0, m_tdata}, {1'b0, held});
      end
      if (pct == 100 && mid_pkt)
        chk("no_bubble", 65'(m_tvalid), 65'd1);
      stalled = 1'b0;
      mid_pkt = 1'b0;
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tdata});
        mid_pkt = !m_tlast && (got_q.size() < n);
      end else if (m_tvalid) begin
        stalled = 1'b1;
        held    = m_tdata;
      end
      @(negedge clk);
    end
    m_tready = 1'b0;
    chk("out_count", 65'(got_q.size()), 65'(n));
  endtask

  task automatic compare(string tag, int n);
    for (int i = 0; i < n; i++)
      chk(tag, got_q[i], exp_q[i]);
  endtask

  task automatic fill_pdu(int n);
    pdu_q.delete();
    for (int i = 0; i < n; i++)
      pdu_q.push_back({$urandom(), $urandom()});
  endtask

  task automatic run_pdu(string tag, int n, int pct, logic [15:0] s,
                         logic [7:0] c, logic [1:0] p, int drop_at);
    @(negedge clk);
    fill_pdu(n);
    cfg_stream_id = s;
    cfg_cos       = c;
    cfg_prio      = p;
    cfg_enable    = 1'b1;
    build_exp(n, s, c, p);
    fork
      send(n, 1'b1, drop_at);
      collect(exp_q.size(), pct);
    join
    cfg_enable = 1'b0;
    compare(tag, exp_q.size());
    exp_pdus++;
    #1;
    chk({tag, "_pdus"}, 65'(pdu_count), 65'(exp_pdus));
  endtask

  initial begin
    rst           = 1'b1;
    cfg_enable    = 1'b0;
    cfg_stream_id = '0;
    cfg_cos       = '0;
    cfg_prio      = '0;
    s_tvalid      = 1'b0;
    s_tdata       = '0;
    s_tlast       = 1'b0;
    m_tready      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_tready", 65'(s_tready), 65'd0);
    chk("rst_m_tvalid", 65'(m_tvalid), 65'd0);
    chk("rst_m_tlast", 65'(m_tlast), 65'd0);
    chk("rst_m_tdata", 65'(m_tdata), 65'd0);
    chk("rst_pdus", 65'(pdu_count), 65'd0);
    chk("rst_sat", 65'(len_sat_err), 65'd0);
    rst = 1'b0;

    run_pdu("pdu3", 3, 100, 16'h1234, 8'h05, 2'd2, -1);
    chk("hdr_const", got_q[0], {1'b0, 64'h9980_0512_3400_0018});

    run_pdu("pdu32", 32, 100, 16'h0BEE, 8'h11, 2'd1, -1);
    run_pdu("pdu70", 70, 100, 16'hCAFE, 8'h3C, 2'd3, -1);
    run_pdu("pdu70_bp", 70, 50, 16'h0F0F, 8'hA5, 2'd0, -1);
    run_pdu("pdu40_drop", 40, 70, 16'hABCD, 8'h42, 2'd1, 10);

    repeat (5) @(negedge clk);
    #1;
    chk("idle_s_tready", 65'(s_tready), 65'd0);
    chk("idle_m_tvalid", 65'(m_tvalid), 65'd0);

    @(negedge clk);
    fill_pdu(70);
    cfg_stream_id = 16'h7777;
    cfg_cos       = 8'h01;
    cfg_prio      = 2'd2;
    cfg_enable    = 1'b1;
    build_exp(70, 16'h7777, 8'h01, 2'd2);
    fork
      send(64, 1'b0, -1);
      collect(38, 100);
    join
    cfg_enable = 1'b0;
    compare("pre_rst", 38);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_s_tready", 65'(s_tready), 65'd0);
    chk("mid_m_tvalid", 65'(m_tvalid), 65'd0);
    chk("mid_m_tlast", 65'(m_tlast), 65'd0);
    chk("mid_m_tdata", 65'(m_tdata), 65'd0);
    chk("mid_pdus", 65'(pdu_count), 65'd0);
    rst = 1'b0;
    exp_pdus = 0;

    run_pdu("post_rst", 3, 100, 16'h2468, 8'h09, 2'd0, -1);
    chk("post_rst_s", 65'(got_q[0][56]), 65'd1);

    chk("sat_before", 65'(len_sat_err), 65'd0);
    run_pdu("sat", 8192, 100, 16'h4321, 8'h77, 2'd3, -1);
    chk("sat_after", 65'(len_sat_err), 65'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/srio_type9_pack.md
Name: srio_type9_pack

Overview:
- Transmit-side counterpart of the type 9 unpacker: takes 64-bit AXIS PDUs and segments them into SRIO type 9 (data streaming) packets.
- Each packet is one header beat followed by up to MTU_BEATS payload beats.
- Sits between a DMA/PDU source and the SRIO core's transmit user port.
- Buffers one whole segment before sending its header, because the header must carry the start/end flags and, on the final segment, the PDU length.

Parameters:
- MTU_BEATS, 32, maximum payload beats (8 bytes each) per segment; legal range 2..256.
- BUF_AW, 8, segment-buffer address width; must satisfy 2^BUF_AW >= MTU_BEATS.

Ports:
- AXIS_ACLK  in  1  sole clock.
- AXIS_ARESET  in  1  synchronous, active-high reset.
- cfg_enable  in  1  allows a new PDU to start.
- cfg_stream_id  in  16  type 9 streamID.
- cfg_cos  in  8  class of service.
- cfg_prio  in  2  SRIO priority.
- S_AXIS_TVALID  in  1  PDU data valid.
- S_AXIS_TREADY  out  1  PDU data ready.
- S_AXIS_TDATA  in  64  PDU data; all 8 bytes of every beat are valid.
- S_AXIS_TLAST  in  1  last beat of the PDU.
- M_AXIS_TVALID  out  1  packet beat valid.
- M_AXIS_TREADY  in  1  SRIO core ready.
- M_AXIS_TDATA  out  64  header or payload beat.
- M_AXIS_TLAST  out  1  last beat of the packet.
- pdu_count  out  32  PDUs fully sent; wraps.
- len_sat_err  out  1  sticky; set when a PDU exceeded 65535 bytes.

Behaviour:
- The design has one clock domain. AXIS_ARESET is synchronous and active-high.
- Reset values: S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, pdu_count=0, len_sat_err=0. All pointers and counters reset to 0, first_seg=1, state=IDLE.
- Reset asserted mid-operation discards the partial PDU and its buffered data. No header is ever emitted for a discarded PDU.
- IDLE:
  - S_AXIS_TREADY=0.
  - When cfg_enable=1, latch cfg_stream_id, cfg_cos and cfg_prio into shadow registers, then go to FILL.
  - The shadow values hold for the whole PDU.
- FILL:
  - S_AXIS_TREADY=1. Each accepted beat is written to buf[wr_cnt] and wr_cnt increments.
  - byte_len adds 8 per beat, saturating at 16'hFFFF. Saturation sets len_sat_err.
  - Leave for HDR when the accepted beat has TLAST=1 (set last_seg=1) or when wr_cnt reaches MTU_BEATS (last_seg=0). If both happen on the same beat, TLAST wins and the segment is an end segment.
- HDR:
  - S_AXIS_TREADY=0. M_AXIS_TVALID=1, TLAST=0. The header is valid the cycle after the closing beat is accepted.
  - Header layout:
    - [63:60]=4'h9
    - [59:58]=prio
    - [57]=0
    - [56]=first_seg
    - [55]=last_seg
    - [54:48]=0
    - [47:40]=cos
    - [39:24]=stream_id
    - [23:16]=seg_idx
    - [15:0]=byte_len if last_seg, else 0
  - A single-segment PDU has bits 56 and 55 both set.
  - On handshake, go to DATA with rd_ptr=0.
- DATA:
  - Present buf[rd_ptr]. M_AXIS_TLAST=1 when rd_ptr==wr_cnt-1.
  - rd_ptr advances only on TVALID&TREADY.
  - TDATA and TVALID must stay stable while TREADY=0. No bubbles are allowed between handshakes when TREADY stays high; prefetch as needed.
  - After the final handshake, clear wr_cnt and first_seg, and increment seg_idx (8-bit, wraps 255->0).
  - If last_seg=1: pdu_count++, first_seg=1, seg_idx=0, byte_len=0, then go to IDLE.
  - If last_seg=0: go to FILL.
- cfg_enable is sampled only in IDLE. Deasserting it mid-PDU lets the PDU complete.
- There is no input/output overlap: S_AXIS_TREADY=0 throughout HDR and DATA.

Test Plan:
- 3-beat PDU (D0..D2, TLAST on D2), stream_id=16'h1234, cos=8'h05, prio=2 -> 4 output beats. Header is 64'h9_?.. with bits 56=1, 55=1, [47:40]=05, [39:24]=1234, [23:16]=0, [15:0]=24; payload D0..D2; TLAST only on D2; pdu_count=1.
- 32-beat PDU with MTU_BEATS=32 -> one packet of 33 beats, S=E=1, length=256.
- 70-beat PDU -> three packets:
  - 32 beats, S=1, E=0, idx 0, len 0.
  - 32 beats, S=0, E=0, idx 1, len 0.
  - 6 beats, S=0, E=1, idx 2, len 560.
  - Payload order preserved.
- Random M_AXIS_TREADY toggling (about 50%) on the 70-beat PDU -> identical beat sequence, held data stable while stalled, no dropped or duplicated beats.
- cfg_enable dropped after 10 of 40 beats, cfg_stream_id changed mid-PDU -> PDU completes with the original stream_id; block then stays in IDLE with S_AXIS_TREADY=0.
- AXIS_ARESET pulsed during the DATA phase of segment 2 -> next cycle all outputs are at reset values; next PDU starts with seg_idx=0, S=1, and pdu_count=0.
